// File: rtl/data_sram_responder.sv
// Data-memory responder: word-organised SRAM with programmable access latency (1..15).
// Request in IDLE at cycle t completes at t+LATENCY; stall holds the M stage until then.
module data_sram_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [3:0]  i_wen,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_resp_valid,
  output logic        o_stall,
  output logic        o_addr_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_sram_responder: LATENCY must be in 1..15");
  end
  if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
    $error("data_sram_responder: ADDR_W must be in 1..29");
  end

  localparam logic [3:0] LP_CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_cnt;
  logic [31:0]        r_addr;
  logic [3:0]         r_wen;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_resp_valid;
  logic               r_addr_err;
  logic [31:0]        r_mem [0:(2**ADDR_W)-1];

  logic               w_accept;
  logic               w_commit;
  logic [31:0]        w_c_addr;
  logic [3:0]         w_c_wen;
  logic [31:0]        w_c_wdata;
  logic [ADDR_W-1:0]  w_c_word;
  logic               w_c_oor;
  logic               w_unused;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_en) w_next = (LATENCY == 1) ? S_DONE : S_BUSY;
      S_BUSY:  if (r_cnt == 4'd1) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_stall  = ((r_state == S_IDLE) && i_en) || (r_state == S_BUSY);
    w_accept = (r_state == S_IDLE) && i_en;
    w_commit = (w_next == S_DONE) && (r_state != S_DONE);
  end

  // With LATENCY=1 the commit happens on the accept edge, before the capture regs load.
  always_comb begin
    w_c_addr  = (r_state == S_IDLE) ? i_addr  : r_addr;
    w_c_wen   = (r_state == S_IDLE) ? i_wen   : r_wen;
    w_c_wdata = (r_state == S_IDLE) ? i_wdata : r_wdata;
    w_c_word  = w_c_addr[ADDR_W+1:2];
    w_c_oor   = |w_c_addr[31:ADDR_W+2];
  end

  assign w_unused = ^r_addr[1:0];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt        <= 4'd0;
      r_addr       <= 32'd0;
      r_wen        <= 4'd0;
      r_wdata      <= 32'd0;
      r_rdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_addr_err   <= 1'b0;
      if (w_accept) begin
        r_addr  <= i_addr;
        r_wen   <= i_wen;
        r_wdata <= i_wdata;
        r_cnt   <= LP_CNT_INIT;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_resp_valid <= 1'b1;
        r_addr_err   <= w_c_oor;
        r_rdata      <= w_c_oor ? 32'd0 : r_mem[w_c_word];
      end
    end
  end

  // Array is not reset; reset held low on a commit edge suppresses the write.
  always_ff @(posedge i_clk) begin
    if (w_commit && i_rst && !w_c_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_c_wen[i]) r_mem[w_c_word][8*i +: 8] <= w_c_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata      = r_rdata;
  assign o_resp_valid = r_resp_valid;
  assign o_addr_err   = r_addr_err;

endmodule
